// File: rtl/core_pkg.sv
// Shared core types: scoreboard slot record, width helpers, counter width.
// Used by issue_scoreboard (optional ISSUE_SCOREBOARD_FWD_EN forwarding).
package core_pkg;

  localparam int STALL_CNT_W = 16;
  localparam int SB_RD_W     = 8;

  typedef struct packed {
    logic               vld;
    logic [SB_RD_W-1:0] rd;
    logic               we;
  } sb_slot_t;

  function automatic int reg_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int idx_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/sb_src_match.sv
// Youngest-match priority encoder for one source operand.
// Returns hit plus the lowest slot index whose pending write matches rs.
module sb_src_match
  import core_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int IDXW  = idx_w(DEPTH)
) (
  input  sb_slot_t [DEPTH-1:0] slots,
  input  logic [SB_RD_W-1:0]   rs,
  input  logic                 used,
  output logic                 hit,
  output logic [IDXW-1:0]      idx
);

  // Scan oldest to youngest so the youngest match is written last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (used && (rs != '0) && slots[k].vld &&
          slots[k].we && (slots[k].rd == rs)) begin
        hit = 1'b1;
        idx = IDXW'(k);
      end
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// RAW hazard scoreboard beside the issue stage with saturating stall count.
// Define ISSUE_SCOREBOARD_FWD_EN to add operand bypass from stage results.
module issue_scoreboard
  import core_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int NREG  = 32,
  parameter  int DEPTH = 3,
  localparam int REGW  = reg_w(NREG)
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   iss_valid,
  input  logic [REGW-1:0]        iss_rs1,
  input  logic [REGW-1:0]        iss_rs2,
  input  logic                   iss_rs1_used,
  input  logic                   iss_rs2_used,
  input  logic [REGW-1:0]        iss_rd,
  input  logic                   iss_we,
  output logic                   iss_ready,
  input  logic                   flush,
  input  logic [DEPTH*XLEN-1:0]  stage_res,
  input  logic [DEPTH-1:0]       stage_res_vld,
`ifdef ISSUE_SCOREBOARD_FWD_EN
  output logic                   fwd_a_en,
  output logic                   fwd_b_en,
  output logic [XLEN-1:0]        fwd_a_data,
  output logic [XLEN-1:0]        fwd_b_data,
`endif
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int IDXW = idx_w(DEPTH);

  sb_slot_t [DEPTH-1:0]   slots_q, slots_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic            hit_a, hit_b;
  logic [IDXW-1:0] idx_a, idx_b;
  logic            stall_a, stall_b;
  logic            fire;

  sb_src_match #(.DEPTH(DEPTH), .IDXW(IDXW)) u_match_a (
    .slots (slots_q),
    .rs    (SB_RD_W'(iss_rs1)),
    .used  (iss_rs1_used),
    .hit   (hit_a),
    .idx   (idx_a)
  );

  sb_src_match #(.DEPTH(DEPTH), .IDXW(IDXW)) u_match_b (
    .slots (slots_q),
    .rs    (SB_RD_W'(iss_rs2)),
    .used  (iss_rs2_used),
    .hit   (hit_b),
    .idx   (idx_b)
  );

`ifdef ISSUE_SCOREBOARD_FWD_EN
  // Bypass from the youngest matching slot once its result is final.
  always_comb begin
    fwd_a_en   = 1'b0;
    fwd_b_en   = 1'b0;
    fwd_a_data = '0;
    fwd_b_data = '0;
    stall_a    = hit_a && !stage_res_vld[idx_a];
    stall_b    = hit_b && !stage_res_vld[idx_b];
    if (hit_a && stage_res_vld[idx_a]) begin
      fwd_a_en   = 1'b1;
      fwd_a_data = stage_res[int'(idx_a)*XLEN +: XLEN];
    end
    if (hit_b && stage_res_vld[idx_b]) begin
      fwd_b_en   = 1'b1;
      fwd_b_data = stage_res[int'(idx_b)*XLEN +: XLEN];
    end
  end
`else
  logic unused_stage;
  assign unused_stage = ^{stage_res, stage_res_vld, idx_a, idx_b};

  // No bypass path: any pending writer blocks the reader.
  always_comb begin
    stall_a = hit_a;
    stall_b = hit_b;
  end
`endif

  assign iss_ready = !flush && !stall_a && !stall_b;
  assign fire      = iss_valid && iss_ready;
  assign stall_cnt = stall_cnt_q;

  // Shift the slot pipeline, insert the issuing instruction, count stalls.
  always_comb begin
    slots_d = '0;
    for (int k = 1; k < DEPTH; k++) begin
      slots_d[k] = slots_q[k-1];
    end
    if (fire) begin
      slots_d[0].vld = 1'b1;
      slots_d[0].rd  = SB_RD_W'(iss_rd);
      slots_d[0].we  = iss_we && (iss_rd != '0);
    end
    if (flush) begin
      slots_d = '0;
    end
    stall_cnt_d = stall_cnt_q;
    if (iss_valid && !iss_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      slots_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      slots_q     <= slots_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized and directed checks of issue_scoreboard against a cycle model.
// Follows ISSUE_SCOREBOARD_FWD_EN to exercise the forwarding build too.
module tb_issue_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int DEPTH = 3;
  localparam int REGW  = 5;

  logic                  clk = 1'b0;
  logic                  nrst;
  logic                  iss_valid;
  logic [REGW-1:0]       iss_rs1, iss_rs2, iss_rd;
  logic                  iss_rs1_used, iss_rs2_used, iss_we;
  logic                  iss_ready;
  logic                  flush;
  logic [DEPTH*XLEN-1:0] stage_res;
  logic [DEPTH-1:0]      stage_res_vld;
  logic [15:0]           stall_cnt;
`ifdef ISSUE_SCOREBOARD_FWD_EN
  logic                  fwd_a_en, fwd_b_en;
  logic [XLEN-1:0]       fwd_a_data, fwd_b_data;
`endif

  always #5 clk = ~clk;

  issue_scoreboard #(.XLEN(XLEN), .NREG(NREG), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .iss_valid     (iss_valid),
    .iss_rs1       (iss_rs1),
    .iss_rs2       (iss_rs2),
    .iss_rs1_used  (iss_rs1_used),
    .iss_rs2_used  (iss_rs2_used),
    .iss_rd        (iss_rd),
    .iss_we        (iss_we),
    .iss_ready     (iss_ready),
    .flush         (flush),
    .stage_res     (stage_res),
    .stage_res_vld (stage_res_vld),
`ifdef ISSUE_SCOREBOARD_FWD_EN
    .fwd_a_en      (fwd_a_en),
    .fwd_b_en      (fwd_b_en),
    .fwd_a_data    (fwd_a_data),
    .fwd_b_data    (fwd_b_data),
`endif
    .stall_cnt     (stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model: cycle of most recent committed-to-track write per register,
  // and the first cycle whose issues survive the last flush/reset.
  int t = 0;
  int lw[NREG];
  int kill = 0;
  int mcnt = 0;

  function automatic bit busy(input int r);
    return (r != 0) && (lw[r] >= kill) && (lw[r] < t) &&
           (t - lw[r] <= DEPTH);
  endfunction

  function automatic bit src_stall(input bit used, input int r);
    if (!used || !busy(r)) return 1'b0;
`ifdef ISSUE_SCOREBOARD_FWD_EN
    return !stage_res_vld[t - lw[r] - 1];
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit m_ready();
    return !flush && !src_stall(iss_rs1_used, int'(iss_rs1)) &&
           !src_stall(iss_rs2_used, int'(iss_rs2));
  endfunction

  task automatic exp_fwd(input bit used, input int r,
                         output bit en, output logic [XLEN-1:0] d);
    en = 1'b0;
    d  = '0;
    if (used && busy(r) && stage_res_vld[t - lw[r] - 1]) begin
      en = 1'b1;
      d  = stage_res[(t - lw[r] - 1)*XLEN +: XLEN];
    end
  endtask

  task automatic tick();
    bit rdy;
    rdy = m_ready();
    if (!nrst) begin
      kill = t + 1;
      mcnt = 0;
    end else begin
      if (flush) kill = t + 1;
      if (iss_valid && rdy && iss_we && iss_rd != 0) lw[iss_rd] = t;
      if (iss_valid && !rdy && mcnt < 65535) mcnt++;
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle();
    iss_valid     = 1'b0;
    iss_rs1       = '0;
    iss_rs2       = '0;
    iss_rs1_used  = 1'b0;
    iss_rs2_used  = 1'b0;
    iss_rd        = '0;
    iss_we        = 1'b0;
    flush         = 1'b0;
    stage_res     = '0;
    stage_res_vld = '0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i <= DEPTH; i++) tick();
  endtask

  task automatic test_reset();
    idle();
    nrst = 1'b0;
    #3;
    tick();
    nrst         = 1'b1;
    iss_valid    = 1'b1;
    iss_rs1      = 5'd5;
    iss_rs1_used = 1'b1;
    #3;
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", iss_ready);
    end
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
    end
`ifdef ISSUE_SCOREBOARD_FWD_EN
    checks++;
    if ({fwd_a_en, fwd_b_en, fwd_a_data, fwd_b_data} !== '0) begin
      errors++;
      $display("FAIL reset_fwd: got %b/%b %h %h want 0",
               fwd_a_en, fwd_b_en, fwd_a_data, fwd_b_data);
    end
`endif
    tick();
    idle();
    #3;
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL idle_cnt: got %0d want 0", stall_cnt);
    end
  endtask

  task automatic test_raw();
    int n;
    int c0;
    int exp_n;
`ifdef ISSUE_SCOREBOARD_FWD_EN
    exp_n = 0;
`else
    exp_n = DEPTH;
`endif
    drain();
    iss_valid     = 1'b1;
    iss_rd        = 5'd5;
    iss_we        = 1'b1;
    stage_res_vld = '1;
    #3;
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL raw_producer: got %b want 1", iss_ready);
    end
    tick();
    iss_rd       = '0;
    iss_we       = 1'b0;
    iss_rs1      = 5'd5;
    iss_rs1_used = 1'b1;
    c0 = mcnt;
    n  = 0;
    while (n < 20) begin
      #3;
      if (iss_ready === 1'b1) break;
      n++;
      tick();
    end
    checks++;
    if (n != exp_n) begin
      errors++;
      $display("FAIL raw_stall_cycles: got %0d want %0d", n, exp_n);
    end
    checks++;
    if (stall_cnt !== 16'(c0 + exp_n)) begin
      errors++;
      $display("FAIL raw_stall_cnt: got %0d want %0d", stall_cnt, c0 + exp_n);
    end
    tick();
  endtask

  task automatic test_x0();
    drain();
    iss_valid = 1'b1;
    iss_rd    = 5'd0;
    iss_we    = 1'b1;
    tick();
    iss_we       = 1'b0;
    iss_rs1      = 5'd0;
    iss_rs1_used = 1'b1;
    iss_rs2      = 5'd0;
    iss_rs2_used = 1'b1;
    #3;
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_ready: got %b want 1", iss_ready);
    end
    tick();
  endtask

  task automatic test_flush();
    drain();
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    iss_we    = 1'b1;
    tick();
    iss_rd       = '0;
    iss_we       = 1'b0;
    iss_rs2      = 5'd7;
    iss_rs2_used = 1'b1;
    flush        = 1'b1;
    #3;
    checks++;
    if (iss_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got %b want 0", iss_ready);
    end
    tick();
    flush = 1'b0;
    #3;
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_flush_ready: got %b want 1", iss_ready);
    end
    tick();
  endtask

`ifdef ISSUE_SCOREBOARD_FWD_EN
  task automatic test_fwd();
    drain();
    iss_valid = 1'b1;
    iss_we    = 1'b1;
    iss_rd    = 5'd9;
    tick();
    iss_rd = 5'd3;
    tick();
    iss_rd = 5'd9;
    tick();
    iss_we        = 1'b0;
    iss_rd        = '0;
    iss_rs1       = 5'd9;
    iss_rs1_used  = 1'b1;
    stage_res     = {32'h5555_5555, 32'h1234_5678, 32'hAAAA_0000};
    stage_res_vld = '1;
    #3;
    checks++;
    if (fwd_a_en !== 1'b1 || fwd_a_data !== 32'hAAAA_0000) begin
      errors++;
      $display("FAIL fwd_young: got %b %h want 1 aaaa0000",
               fwd_a_en, fwd_a_data);
    end
    stage_res_vld = 3'b110;
    #1;
    checks++;
    if (iss_ready !== 1'b0 || fwd_a_en !== 1'b0) begin
      errors++;
      $display("FAIL fwd_young_invalid: got rdy %b en %b want 0 0",
               iss_ready, fwd_a_en);
    end
    idle();
    tick();
  endtask
`endif

  task automatic test_random();
    bit  er;
`ifdef ISSUE_SCOREBOARD_FWD_EN
    bit ea, eb;
    logic [XLEN-1:0] da, db;
`endif
    for (int i = 0; i < 3000; i++) begin
      nrst         = ($urandom_range(199) != 0);
      iss_valid    = ($urandom_range(3) != 0);
      iss_rs1      = REGW'($urandom_range(7));
      iss_rs2      = REGW'($urandom_range(7));
      iss_rs1_used = $urandom_range(1);
      iss_rs2_used = $urandom_range(1);
      iss_rd       = REGW'($urandom_range(7));
      iss_we       = ($urandom_range(3) != 0);
      flush        = ($urandom_range(15) == 0);
      for (int k = 0; k < DEPTH; k++) stage_res[k*XLEN +: XLEN] = $urandom;
      stage_res_vld = DEPTH'($urandom);
      #3;
      er = m_ready();
      checks++;
      if (iss_ready !== er) begin
        errors++;
        $display("FAIL rnd_ready t=%0d: got %b want %b", t, iss_ready, er);
      end
      checks++;
      if (stall_cnt !== 16'(mcnt)) begin
        errors++;
        $display("FAIL rnd_cnt t=%0d: got %0d want %0d", t, stall_cnt, mcnt);
      end
`ifdef ISSUE_SCOREBOARD_FWD_EN
      exp_fwd(iss_rs1_used, int'(iss_rs1), ea, da);
      exp_fwd(iss_rs2_used, int'(iss_rs2), eb, db);
      checks++;
      if (fwd_a_en !== ea || fwd_a_data !== da ||
          fwd_b_en !== eb || fwd_b_data !== db) begin
        errors++;
        $display("FAIL rnd_fwd t=%0d: got %b %h %b %h want %b %h %b %h", t,
                 fwd_a_en, fwd_a_data, fwd_b_en, fwd_b_data, ea, da, eb, db);
      end
`endif
      tick();
    end
    nrst = 1'b1;
    idle();
  endtask

  task automatic test_saturation();
    idle();
    nrst = 1'b0;
    tick();
    nrst      = 1'b1;
    iss_valid = 1'b1;
    flush     = 1'b1;
    for (int i = 0; i < 65535 + 2; i++) tick();
    #3;
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_cnt: got %h want ffff", stall_cnt);
    end
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    idle();
    #3;
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL sat_reset_cnt: got %h want 0", stall_cnt);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < NREG; r++) lw[r] = -1000000;
    nrst = 1'b0;
    idle();
    test_reset();
    test_raw();
    test_x0();
    test_flush();
`ifdef ISSUE_SCOREBOARD_FWD_EN
    test_fwd();
`endif
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

- Parametrised hazard scoreboard for the in-order core; it sits beside the issue stage.
- Tracks the destination register of every instruction between issue and write-back in a DEPTH-slot shift pipeline.
- Holds issue (`iss_ready` low) on read-after-write hazards and counts stall cycles.
- With forwarding compiled in, it instead supplies bypass values from downstream stages when they are ready.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `NREG`, 32, architectural register count; `REGW` = $clog2(NREG).
- `DEPTH`, 3, stages from issue to write-back inclusive (exe, mem, commit); legal range 1..8.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: core clock; all state updates on its rising edge.
- `nrst` in 1: synchronous, active-low reset.
- `iss_valid` in 1: decoded instruction present at issue.
- `iss_rs1`, `iss_rs2` in REGW: source register indices.
- `iss_rs1_used`, `iss_rs2_used` in 1: the instruction reads that source.
- `iss_rd` in REGW: destination register index.
- `iss_we` in 1: the instruction writes `iss_rd`.
- `iss_ready` out 1: the instruction may issue this cycle. Issue fires on `iss_valid & iss_ready`.
- `flush` in 1: kill all in-flight tracking (redirect).
- `stage_res` in DEPTH*XLEN: result word of slot k at bits [k*XLEN +: XLEN].
- `stage_res_vld` in DEPTH: slot k result is final.
- `fwd_a_en`, `fwd_b_en` out 1: use the forwarded operand. Exists only with the macro.
- `fwd_a_data`, `fwd_b_data` out XLEN: forwarded operand. Exists only with the macro.
- `stall_cnt` out 16: saturating count of stalled cycles.

## Operation
- State: DEPTH slots, each {vld, rd, we}. Slot 0 is the youngest (in exe); slot DEPTH-1 is writing the register file this cycle.
- Every cycle all slots shift: slot k+1 <= slot k. Downstream stages never stall.
- On fire, slot 0 <= {1, iss_rd, iss_we & (iss_rd != 0)}; otherwise slot 0 <= bubble (vld=0).
- Hazard for source s: rs_used & rs != 0 & some slot k has vld & we & rd == rs.
- Without `FWD_EN`: `iss_ready` = !flush & no hazard on rs1 or rs2. Slot DEPTH-1 counts as a hazard, because the register file has no write-through.
- Priority: the youngest matching slot (lowest k) decides, since it holds the newest value.
- x0 is never tracked and never hazards.
- `flush` = 1: all slots are cleared at the next edge, and `iss_ready` = 0 that cycle. An instruction presented with flush is neither issued nor recorded.
- `stall_cnt` increments on any cycle with `iss_valid & !iss_ready`, flush cycles included. It saturates at 0xFFFF and does not wrap.
- Reset (`nrst` = 0 at an edge): all slots vld=0 and `stall_cnt` = 0. This holds even mid-stream; any in-flight tracking is simply lost.

## Timing
- `iss_ready` and `fwd_*` are combinational from the slots plus current issue inputs; the decision is made in the same cycle.
- Slot and counter updates are registered, so an issued instruction is visible as a hazard from the next cycle.
- Without forwarding, a dependent instruction directly behind its producer stalls DEPTH cycles. With forwarding and `stage_res_vld` all 1, it stalls 0 cycles.
- Reset values:
  - `iss_ready` = 1 when `flush` = 0 (no valid slots).
  - `fwd_a_en` = `fwd_b_en` = 0 and `fwd_a_data` = `fwd_b_data` = 0.
  - `stall_cnt` = 0.

## Configuration
- Macro `ISSUE_SCOREBOARD_FWD_EN`.
- Defined: for each source, find the youngest matching slot k.
  - If `stage_res_vld[k]`: `fwd_x_en` = 1, `fwd_x_data` = stage_res slot k, and no stall from that source.
  - Otherwise stall. An older valid match never overrides a younger invalid one.
- Undefined: the `fwd_*` ports are absent and every hazard stalls.

## Structure
- Shared package `core_pkg`: `sb_slot_t` struct {vld, rd, we}, `REGW` derivation helper, and `STALL_CNT_W` = 16.
- One sub-module, `sb_src_match`: per-source youngest-match priority encoder returning {hit, index}. It is instantiated twice (rs1 and rs2).

## Test plan
- Reset then idle: `iss_valid` = 1, rs1 = 5, no slots valid -> `iss_ready` = 1 and `stall_cnt` stays 0.
- No forwarding, DEPTH = 3: issue rd = 5, then rs1 = 5 the next cycle -> `iss_ready` low for exactly 3 cycles and `stall_cnt` = 3.
- x0: issue rd = 0 with we = 1, then rs1 = 0 -> no stall.
- Flush: issue rd = 7, then assert `flush` with rs2 = 7 presented -> `iss_ready` = 0 that cycle; the next cycle rs2 = 7 issues with no stall.
- `FWD_EN`: producers rd = 9 in slots 0 and 2, stage_res slot 0 = 0xAAAA_0000 with vld = 1 -> `fwd_a_en` = 1 and data = 0xAAAA_0000. With slot 0 vld = 0 -> stall.
- Saturation: force 0xFFFF stalled cycles plus 2 -> `stall_cnt` = 0xFFFF. Then assert `nrst` = 0 for one edge -> `stall_cnt` = 0.
